// File: rtl/jump_trajectory_gen.sv
// Tick-enabled ballistic jump generator: height under constant gravity, linear distance.
// Optional JUMP_TRAJ_TICK_SYNC_EN: i_tick is a raw slow square wave, synchronised and edge-detected.
module jump_trajectory_gen #(
    parameter int unsigned GRAV  = 1,
    parameter int unsigned FRAC  = 5,
    parameter int unsigned DSTEP = 32
) (
    input  logic        clk_machine,
    input  logic        rst_machine,
    input  logic        i_en,
    input  logic [10:0] i_v_init,
    input  logic        i_tick,
    output logic [8:0]  o_height,
    output logic [10:0] o_dist,
    output logic        o_done,
    output logic        o_busy
);

    typedef enum logic [1:0] {StIdle, StFlight, StLanded} state_e;

    state_e             r_state;
    logic signed [12:0] r_v;
    logic signed [23:0] r_h_acc;
    logic [15:0]        r_d_acc;

    logic               w_tick;
    logic signed [23:0] w_h_next;
    logic [16:0]        w_d_sum;
    logic [15:0]        w_d_next;

`ifdef JUMP_TRAJ_TICK_SYNC_EN
    logic r_tick_s1, r_tick_s2, r_tick_s3;

    always_ff @(posedge clk_machine) begin
        if (rst_machine) begin
            r_tick_s1 <= 1'b0;
            r_tick_s2 <= 1'b0;
            r_tick_s3 <= 1'b0;
        end else begin
            r_tick_s1 <= i_tick;
            r_tick_s2 <= r_tick_s1;
            r_tick_s3 <= r_tick_s2;
        end
    end

    assign w_tick = r_tick_s2 & ~r_tick_s3;
`else
    assign w_tick = i_tick;
`endif

    assign w_h_next = r_h_acc + $signed({{11{r_v[12]}}, r_v});
    // Distance saturates rather than wrapping so long jumps pin at the maximum.
    assign w_d_sum  = {1'b0, r_d_acc} + 17'(DSTEP);
    assign w_d_next = w_d_sum[16] ? 16'hFFFF : w_d_sum[15:0];

    function automatic logic [8:0] height_px(input logic [23:0] acc);
        logic [23:0] px;
        px = acc >> FRAC;
        return (px > 24'd511) ? 9'd511 : px[8:0];
    endfunction

    function automatic logic [10:0] dist_px(input logic [15:0] acc);
        logic [15:0] px;
        px = acc >> FRAC;
        return (px > 16'd2047) ? 11'd2047 : px[10:0];
    endfunction

    always_ff @(posedge clk_machine) begin
        if (rst_machine) begin
            r_state  <= StIdle;
            r_v      <= '0;
            r_h_acc  <= '0;
            r_d_acc  <= '0;
            o_height <= '0;
            o_dist   <= '0;
            o_done   <= 1'b0;
            o_busy   <= 1'b0;
        end else if (!i_en) begin
            r_state  <= StIdle;
            r_h_acc  <= '0;
            r_d_acc  <= '0;
            o_height <= '0;
            o_dist   <= '0;
            o_done   <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_state  <= StFlight;
                    r_v      <= $signed({2'b00, i_v_init});
                    r_h_acc  <= '0;
                    r_d_acc  <= '0;
                    o_height <= '0;
                    o_dist   <= '0;
                    o_busy   <= 1'b1;
                end
                StFlight: begin
                    if (w_tick) begin
                        r_d_acc <= w_d_next;
                        o_dist  <= dist_px(w_d_next);
                        if (w_h_next <= 24'sd0) begin
                            r_h_acc  <= '0;
                            o_height <= '0;
                            r_state  <= StLanded;
                            o_done   <= 1'b1;
                            o_busy   <= 1'b0;
                        end else begin
                            r_h_acc  <= w_h_next;
                            r_v      <= r_v - $signed(13'(GRAV));
                            o_height <= height_px(w_h_next);
                        end
                    end
                end
                StLanded: begin
                    // Held until the FSM drops enable.
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_jump_trajectory_gen.sv
// Directed bench for jump_trajectory_gen; expected values hand-computed from the ballistic sums.
// Define JUMP_TRAJ_TICK_SYNC_EN for both files to exercise the synchronised-tick build instead.
module tb_jump_trajectory_gen;

    logic        clk_machine = 1'b0;
    logic        rst_machine;
    logic        i_en;
    logic [10:0] i_v_init;
    logic        i_tick;
    logic [8:0]  o_height;
    logic [10:0] o_dist;
    logic        o_done;
    logic        o_busy;

    int n_vec = 0;
    int n_err = 0;

    jump_trajectory_gen dut (
        .clk_machine (clk_machine),
        .rst_machine (rst_machine),
        .i_en        (i_en),
        .i_v_init    (i_v_init),
        .i_tick      (i_tick),
        .o_height    (o_height),
        .o_dist      (o_dist),
        .o_done      (o_done),
        .o_busy      (o_busy)
    );

    always #5 clk_machine = ~clk_machine;

    task automatic step();
        @(posedge clk_machine);
        #1;
    endtask

    task automatic test_reset();
        rst_machine = 1'b1;
        i_en        = 1'b1;
        i_tick      = 1'b1;
        i_v_init    = 11'd127;
        step();
        step();
        i_tick = 1'b0;
        i_en   = 1'b0;
        n_vec++;
        if (o_height !== 9'd0) begin n_err++; $display("FAIL reset_height got %0d want 0", o_height); end
        n_vec++;
        if (o_dist !== 11'd0) begin n_err++; $display("FAIL reset_dist got %0d want 0", o_dist); end
        n_vec++;
        if (o_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", o_done); end
        n_vec++;
        if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", o_busy); end
        rst_machine = 1'b0;
        step();
    endtask

`ifndef JUMP_TRAJ_TICK_SYNC_EN
    task automatic test_nominal();
        i_v_init = 11'd127;
        i_en     = 1'b1;
        i_tick   = 1'b0;
        step();
        n_vec++;
        if (o_busy !== 1'b1) begin n_err++; $display("FAIL nom_busy_start got %b want 1", o_busy); end
        for (int k = 1; k <= 255; k++) begin
            i_tick = 1'b1;
            step();
            i_tick = 1'b0;
            if (k == 1) begin
                n_vec++;
                if (o_height !== 9'd3) begin n_err++; $display("FAIL nom_h1 got %0d want 3", o_height); end
            end
            if (k == 127 || k == 128) begin
                n_vec++;
                if (o_height !== 9'd254) begin
                    n_err++; $display("FAIL nom_peak_t%0d got %0d want 254", k, o_height);
                end
            end
            if (k == 128) begin
                n_vec++;
                if (o_dist !== 11'd128) begin n_err++; $display("FAIL nom_d128 got %0d want 128", o_dist); end
            end
            if (k == 254) begin
                n_vec++;
                if (o_height !== 9'd3 || o_done !== 1'b0 || o_busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL nom_t254 got h=%0d done=%b busy=%b want h=3 done=0 busy=1",
                             o_height, o_done, o_busy);
                end
            end
            if (k == 100) i_v_init = 11'd5;
        end
        n_vec++;
        if (o_done !== 1'b1 || o_busy !== 1'b0) begin
            n_err++; $display("FAIL nom_land got done=%b busy=%b want done=1 busy=0", o_done, o_busy);
        end
        n_vec++;
        if (o_dist !== 11'd255 || o_height !== 9'd0) begin
            n_err++; $display("FAIL nom_land_pos got h=%0d d=%0d want h=0 d=255", o_height, o_dist);
        end
        i_tick = 1'b1;
        repeat (3) step();
        i_tick = 1'b0;
        n_vec++;
        if (o_dist !== 11'd255 || o_done !== 1'b1) begin
            n_err++; $display("FAIL nom_landed_hold got d=%0d done=%b want d=255 done=1", o_dist, o_done);
        end
        i_en = 1'b0;
        step();
        n_vec++;
        if (o_height !== 9'd0 || o_dist !== 11'd0 || o_done !== 1'b0 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL nom_drop got h=%0d d=%0d done=%b busy=%b want all 0",
                     o_height, o_dist, o_done, o_busy);
        end
    endtask

    task automatic test_zero_velocity();
        i_v_init = 11'd0;
        i_en     = 1'b1;
        i_tick   = 1'b0;
        step();
        i_tick = 1'b1;
        step();
        n_vec++;
        if (o_done !== 1'b1 || o_dist !== 11'd1 || o_height !== 9'd0) begin
            n_err++;
            $display("FAIL zero_land got done=%b d=%0d h=%0d want done=1 d=1 h=0",
                     o_done, o_dist, o_height);
        end
        i_v_init = 11'd9;
        repeat (3) step();
        i_tick = 1'b0;
        n_vec++;
        if (o_done !== 1'b1 || o_dist !== 11'd1 || o_busy !== 1'b0) begin
            n_err++; $display("FAIL zero_hold got done=%b d=%0d busy=%b want 1/1/0", o_done, o_dist, o_busy);
        end
        i_en = 1'b0;
        step();
    endtask

    task automatic test_abort();
        i_v_init = 11'd127;
        i_en     = 1'b1;
        i_tick   = 1'b0;
        step();
        for (int k = 1; k <= 99; k++) begin
            i_tick = 1'b1;
            step();
        end
        i_tick = 1'b0;
        n_vec++;
        if (o_height !== 9'd241 || o_dist !== 11'd99 || o_done !== 1'b0) begin
            n_err++;
            $display("FAIL abort_t99 got h=%0d d=%0d done=%b want h=241 d=99 done=0",
                     o_height, o_dist, o_done);
        end
        i_tick = 1'b1;
        i_en   = 1'b0;
        step();
        i_tick = 1'b0;
        n_vec++;
        if (o_height !== 9'd0 || o_dist !== 11'd0 || o_done !== 1'b0 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_idle got h=%0d d=%0d done=%b busy=%b want all 0",
                     o_height, o_dist, o_done, o_busy);
        end
    endtask

    task automatic test_mid_reset();
        i_v_init = 11'd127;
        i_en     = 1'b1;
        i_tick   = 1'b1;
        step();
        repeat (10) step();
        rst_machine = 1'b1;
        step();
        n_vec++;
        if (o_height !== 9'd0 || o_dist !== 11'd0 || o_done !== 1'b0 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL midrst got h=%0d d=%0d done=%b busy=%b want all 0",
                     o_height, o_dist, o_done, o_busy);
        end
        rst_machine = 1'b0;
        i_tick      = 1'b0;
        i_en        = 1'b0;
        step();
    endtask

    task automatic test_saturation();
        i_v_init = 11'd2047;
        i_en     = 1'b1;
        i_tick   = 1'b0;
        step();
        i_tick = 1'b1;
        for (int k = 1; k <= 4095; k++) begin
            step();
            if (k == 2047) begin
                n_vec++;
                if (o_height !== 9'd511) begin n_err++; $display("FAIL sat_h got %0d want 511", o_height); end
            end
            if (k == 3000) begin
                n_vec++;
                if (o_dist !== 11'd2047) begin n_err++; $display("FAIL sat_d got %0d want 2047", o_dist); end
            end
            if (k == 4094) begin
                n_vec++;
                if (o_height !== 9'd63 || o_done !== 1'b0) begin
                    n_err++; $display("FAIL sat_t4094 got h=%0d done=%b want h=63 done=0", o_height, o_done);
                end
            end
        end
        i_tick = 1'b0;
        n_vec++;
        if (o_done !== 1'b1 || o_height !== 9'd0 || o_dist !== 11'd2047) begin
            n_err++;
            $display("FAIL sat_land got done=%b h=%0d d=%0d want done=1 h=0 d=2047",
                     o_done, o_height, o_dist);
        end
        i_en = 1'b0;
        step();
    endtask
`else
    task automatic test_sync_tick();
        i_v_init = 11'd3;
        i_en     = 1'b1;
        i_tick   = 1'b0;
        step();
        for (int p = 1; p <= 8; p++) begin
            i_tick = 1'b1;
            repeat (4) step();
            i_tick = 1'b0;
            repeat (4) step();
            if (p == 1) begin
                n_vec++;
                if (o_dist !== 11'd1 || o_height !== 9'd0) begin
                    n_err++; $display("FAIL sync_p1 got d=%0d h=%0d want d=1 h=0", o_dist, o_height);
                end
            end
            if (p == 6) begin
                n_vec++;
                if (o_dist !== 11'd6 || o_done !== 1'b0) begin
                    n_err++; $display("FAIL sync_p6 got d=%0d done=%b want d=6 done=0", o_dist, o_done);
                end
            end
            if (p >= 7) begin
                n_vec++;
                if (o_dist !== 11'd7 || o_done !== 1'b1) begin
                    n_err++;
                    $display("FAIL sync_p%0d got d=%0d done=%b want d=7 done=1", p, o_dist, o_done);
                end
            end
        end
        i_en = 1'b0;
        step();
        n_vec++;
        if (o_dist !== 11'd0 || o_done !== 1'b0) begin
            n_err++; $display("FAIL sync_drop got d=%0d done=%b want 0/0", o_dist, o_done);
        end
    endtask
`endif

    initial begin
        rst_machine = 1'b1;
        i_en        = 1'b0;
        i_v_init    = '0;
        i_tick      = 1'b0;
        test_reset();
`ifndef JUMP_TRAJ_TICK_SYNC_EN
        test_nominal();
        test_zero_velocity();
        test_abort();
        test_mid_reset();
        test_saturation();
`else
        test_sync_tick();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
